// File: rtl/pipe_front_regs_if.sv
// Signal bundle between fetch/decode logic and the front-end pipeline register bank.
// The master side drives the stage inputs and hazard controls; the slave side is the register bank.
interface pipe_front_regs_if #(
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
);
    logic [31:0]       pcnextF;
    logic [31:0]       pcF;
    logic [31:0]       instrF;
    logic [31:0]       pcplus4F;
    logic [31:0]       instrD;
    logic [31:0]       pcplus4D;
    logic              validD;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [CTRL_W-1:0] ctrlD;
    logic [31:0]       rd1D;
    logic [31:0]       rd2D;
    logic [31:0]       signimmD;
    logic [4:0]        rsD;
    logic [4:0]        rtD;
    logic [4:0]        rdD;
    logic [CTRL_W-1:0] ctrlE;
    logic [31:0]       rd1E;
    logic [31:0]       rd2E;
    logic [31:0]       signimmE;
    logic [4:0]        rsE;
    logic [4:0]        rtE;
    logic [4:0]        rdE;
    logic              validE;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stallcnt;
    logic [CNT_W-1:0]  squashcnt;

    modport master (
        output pcnextF, instrF, pcplus4F, StallF, StallD, FlushD, FlushE,
               ctrlD, rd1D, rd2D, signimmD, rsD, rtD, rdD, cnt_clr,
        input  pcF, instrD, pcplus4D, validD, ctrlE, rd1E, rd2E, signimmE,
               rsE, rtE, rdE, validE, stallcnt, squashcnt
    );

    modport slave (
        input  pcnextF, instrF, pcplus4F, StallF, StallD, FlushD, FlushE,
               ctrlD, rd1D, rd2D, signimmD, rsD, rtD, rdD, cnt_clr,
        output pcF, instrD, pcplus4D, validD, ctrlE, rd1E, rd2E, signimmE,
               rsE, rtE, rdE, validE, stallcnt, squashcnt
    );
endinterface

// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers of the 5-stage MIPS core: PC, IF/ID and ID/EX,
// applying hazard-unit stall/flush controls and counting stall and squash events.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 10,
    parameter int          CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_front_regs_if.slave  bus
);

    logic [CNT_W-1:0] cnt_one;
    logic             stall_sat;
    logic             squash_sat;
    logic             squash_event;

    assign cnt_one      = CNT_W'(1);
    assign stall_sat    = &bus.stallcnt;
    assign squash_sat   = &bus.squashcnt;
    // A flush only squashes IF/ID when the stage is not being held.
    assign squash_event = bus.FlushD & ~bus.StallD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pcF <= RESET_PC;
        end else if (!bus.StallF) begin
            bus.pcF <= bus.pcnextF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.instrD   <= 32'h0;
            bus.pcplus4D <= 32'h0;
            bus.validD   <= 1'b0;
        end else if (bus.StallD) begin
            bus.instrD   <= bus.instrD;
            bus.pcplus4D <= bus.pcplus4D;
            bus.validD   <= bus.validD;
        end else if (bus.FlushD) begin
            bus.instrD   <= 32'h0;
            bus.pcplus4D <= 32'h0;
            bus.validD   <= 1'b0;
        end else begin
            bus.instrD   <= bus.instrF;
            bus.pcplus4D <= bus.pcplus4F;
            bus.validD   <= 1'b1;
        end
    end

    // Execute never stalls; a zeroed control bundle makes the bubble architecturally inert.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ctrlE    <= {CTRL_W{1'b0}};
            bus.rd1E     <= 32'h0;
            bus.rd2E     <= 32'h0;
            bus.signimmE <= 32'h0;
            bus.rsE      <= 5'h0;
            bus.rtE      <= 5'h0;
            bus.rdE      <= 5'h0;
            bus.validE   <= 1'b0;
        end else if (bus.FlushE) begin
            bus.ctrlE    <= {CTRL_W{1'b0}};
            bus.rd1E     <= 32'h0;
            bus.rd2E     <= 32'h0;
            bus.signimmE <= 32'h0;
            bus.rsE      <= 5'h0;
            bus.rtE      <= 5'h0;
            bus.rdE      <= 5'h0;
            bus.validE   <= 1'b0;
        end else begin
            bus.ctrlE    <= bus.ctrlD;
            bus.rd1E     <= bus.rd1D;
            bus.rd2E     <= bus.rd2D;
            bus.signimmE <= bus.signimmD;
            bus.rsE      <= bus.rsD;
            bus.rtE      <= bus.rtD;
            bus.rdE      <= bus.rdD;
            bus.validE   <= bus.validD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stallcnt <= '0;
        end else if (bus.cnt_clr) begin
            bus.stallcnt <= '0;
        end else if (bus.StallD && !stall_sat) begin
            bus.stallcnt <= bus.stallcnt + cnt_one;
        end
    end

    // Both counters saturate at all-ones so a long run never wraps to a misleading small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.squashcnt <= '0;
        end else if (bus.cnt_clr) begin
            bus.squashcnt <= '0;
        end else if (squash_event && !squash_sat) begin
            bus.squashcnt <= bus.squashcnt + cnt_one;
        end
    end

endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Front-end pipeline register bank for the 5-stage MIPS core: PC register, IF/ID register and ID/EX register.
- Consumes the stall, flush and bubble controls produced by the hazard unit and the branch logic.
- Applies them cycle-exactly.
- Keeps saturating stall and squash event counters for performance observation.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 10, width of the packed decode-stage control bundle (regwrite, memtoreg, memwrite, alucontrol, alusrc, regdst, ...).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcnextF  in  32  next-PC value.
- pcF  out  32  current fetch PC.
- instrF  in  32  fetched instruction.
- pcplus4F  in  32  fetch PC + 4.
- instrD  out  32  decode-stage instruction.
- pcplus4D  out  32  decode-stage PC + 4.
- validD  out  1  decode stage holds a real instruction.
- StallF  in  1  hold the PC register.
- StallD  in  1  hold the IF/ID register.
- FlushD  in  1  squash the IF/ID register (taken branch or jump).
- FlushE  in  1  insert a bubble into ID/EX.
- ctrlD  in  CTRL_W  decode control bundle.
- rd1D, rd2D, signimmD  in  32 each  decode operands.
- rsD, rtD, rdD  in  5 each  decode register specifiers.
- ctrlE  out  CTRL_W  execute control bundle.
- rd1E, rd2E, signimmE  out  32 each  execute operands.
- rsE, rtE, rdE  out  5 each  execute register specifiers.
- validE  out  1  execute stage holds a real instruction.
- cnt_clr  in  1  synchronous clear of both counters.
- stallcnt  out  CNT_W  number of cycles with StallD high.
- squashcnt  out  CNT_W  number of effective IF/ID squashes.

Behaviour:
- Reset (asynchronous, immediate): pcF=RESET_PC; every other output 0, including instrD (encodes nop), validD, validE and both counters.
- PC register: pcF <= pcnextF when StallF=0; hold when StallF=1.
- IF/ID register, per edge:
  - StallD=1: hold instrD, pcplus4D and validD. StallD has priority over FlushD; a FlushD arriving during a stall is ignored.
  - StallD=0, FlushD=1: instrD=0, pcplus4D=0, validD=0.
  - Otherwise: load instrF and pcplus4F; validD=1.
- ID/EX register has no enable; the execute stage never stalls:
  - FlushE=1: ctrlE, rd1E, rd2E, signimmE, rsE, rtE, rdE all 0; validE=0. Zero ctrlE means no regwrite and no memwrite, so the bubble is architecturally inert.
  - FlushE=0: load every D-side field; validE <= validD. A squashed D slot propagates as a bubble.
- Latency: exactly one cycle per stage; no combinational path from any input to any output.
- stallcnt:
  - +1 on each edge with StallD=1.
  - Saturates at all-ones with no wrap.
- squashcnt:
  - +1 on each edge with FlushD=1 and StallD=0.
  - Saturates at all-ones with no wrap.
- cnt_clr=1 forces both counters to 0 on that edge, overriding any simultaneous increment.
- Combined hazard cycle (StallF=StallD=FlushE=1, the load-use or branch stall):
  - pcF, instrD and validD hold.
  - The E stage receives a bubble.
  - stallcnt +1.
- Reset mid-stall or mid-flush: all state returns to reset values at once. The first edge after reset deassertion follows the normal rules.
- X-safety: outputs never depend on D-side inputs while the corresponding register is held or cleared.

Test Plan:
- Reset: assert reset mid-cycle with RESET_PC=32'h0000_0040 -> pcF=32'h40 immediately; validD=validE=0; counters 0.
- Straight-line flow: pcnextF=8, instrF=32'h2008_0005, no controls -> next edge pcF=8, instrD=32'h2008_0005, validD=1. Following edge: validE=1 and ctrlE equals the prior ctrlD.
- Load-use stall: one cycle with StallF=StallD=FlushE=1 ->
  - pcF and instrD unchanged.
  - ctrlE=0, validE=0.
  - stallcnt 0->1.
  - Next normal edge resumes with the held instruction.
- Taken branch: FlushD=1, StallD=0 -> instrD=0, validD=0, squashcnt +1. Next edge validE=0 and ctrlE=0.
- Stall beats flush: StallD=1 and FlushD=1 together -> instrD held, validD stays 1, squashcnt unchanged, stallcnt +1.
- Counters:
  - CNT_W=4, StallD high for 20 cycles -> stallcnt=4'hF.
  - cnt_clr together with StallD -> stallcnt=0 on that edge.
